// File: rtl/tmp_result_decoder.sv
// ---------------------------------------------------------------------------
// tmp_result_decoder
//
// Receive-side decoder for the temperature-sensor switch-control bus. It
// watches the sequencer's PA/PB/PC/PD phase pattern and its preChrg flag,
// counts high-charge (H) against all (H + L) balancing events over a frame
// of N_SAMPLES events, and publishes the H count to the back end over a
// valid/ready handshake.
//
// Parameters
//   CNT_W      width of the event counters and of code
//   N_SAMPLES  charge events per full frame (1 .. 2^CNT_W-1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   preChrg     sequencer precharge flag; high forces IDLE, its fall starts
//               acquisition
//   PA..PD      sequencer phase switches
//   code_ready  back end accepts code
//   code        H count of the last published frame
//   code_valid  code holds an unconsumed result
//   ovf         sticky: a result was dropped because code was not consumed
//   frame_err   sticky: an illegal phase pattern was seen during ACQ
//   busy        high while acquiring or finishing a frame
//
// Build option
//   TMPDEC_AVG_EN  when defined, four consecutive frame results are summed
//                  and only their truncated average is published.
// ---------------------------------------------------------------------------
module tmp_result_decoder #(
  parameter int CNT_W     = 8,
  parameter int N_SAMPLES = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preChrg,
  input  logic             PA,
  input  logic             PB,
  input  logic             PC,
  input  logic             PD,
  input  logic             code_ready,
  output logic [CNT_W-1:0] code,
  output logic             code_valid,
  output logic             ovf,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_DONE} state_t;
  typedef enum logic [2:0] {C_BLANK, C_H, C_L, C_OUT, C_ILL} class_t;

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  class_t           curClass, prevClass_q;
  logic             preChrg_q, preChrgPrev_q;
  logic [3:0]       phase_q;
  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] nCnt_q, nCnt_d;
  logic [CNT_W-1:0] code_q, code_d;
  logic             codeValid_q, codeValid_d;
  logic             ovf_q, ovf_d;
  logic             frameErr_q, frameErr_d;
  logic             publish;
  logic [CNT_W-1:0] pubVal;
  logic             chargeEvent;
  logic             outRise;

`ifdef TMPDEC_AVG_EN
  logic [1:0]       frameCnt_q, frameCnt_d;
  logic [CNT_W+1:0] acc_q, acc_d;
  logic [CNT_W+1:0] accSum;

  // Running sum including the frame that is finishing right now.
  assign accSum = acc_q + {2'b00, hCnt_q};
`endif

  // Classify the registered phase pattern. The registered copy is the only
  // one used so that every decision sees a stable, synchronised value.
  always_comb begin
    curClass = C_ILL;
    casez (phase_q)
      4'b1100: curClass = C_H;
      4'b1010: curClass = C_L;
      4'b?111: curClass = C_OUT;
      4'b0000: curClass = C_BLANK;
      default: curClass = C_ILL;
    endcase
  end

  // A charge event is the first cycle of an H or L class; holding the same
  // class for several cycles must count once. OUT only matters on its entry.
  assign chargeEvent = (curClass != prevClass_q) &&
                       ((curClass == C_H) || (curClass == C_L));
  assign outRise     = (curClass == C_OUT) && (prevClass_q != C_OUT);

  // Next-state logic. preChrg wins over everything except reset, publishing
  // only happens in DONE, and counting only happens in ACQ, which gives the
  // required priority without any extra arbitration.
  always_comb begin
    state_d     = state_q;
    hCnt_d      = hCnt_q;
    nCnt_d      = nCnt_q;
    code_d      = code_q;
    codeValid_d = codeValid_q;
    ovf_d       = ovf_q;
    frameErr_d  = frameErr_q;
    publish     = 1'b0;
    pubVal      = hCnt_q;
`ifdef TMPDEC_AVG_EN
    frameCnt_d  = frameCnt_q;
    acc_d       = acc_q;
`endif

    if (codeValid_q && code_ready) begin
      codeValid_d = 1'b0;
    end

    if (preChrg_q) begin
      state_d = S_IDLE;
      hCnt_d  = '0;
      nCnt_d  = '0;
`ifdef TMPDEC_AVG_EN
      frameCnt_d = '0;
      acc_d      = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          hCnt_d = '0;
          nCnt_d = '0;
          // preChrg_q is already low here, so a high previous copy is a fall.
          if (preChrgPrev_q) begin
            state_d = S_ACQ;
          end
        end
        S_ACQ: begin
          if (curClass == C_ILL) begin
            frameErr_d = 1'b1;
          end
          if (nCnt_q == N_LAST) begin
            state_d = S_DONE;
          end else if (outRise && (nCnt_q != '0)) begin
            state_d = S_DONE;
          end else if (chargeEvent) begin
            nCnt_d = nCnt_q + ONE;
            if (curClass == C_H) begin
              hCnt_d = hCnt_q + ONE;
            end
          end
        end
        S_DONE: begin
          hCnt_d  = '0;
          nCnt_d  = '0;
          state_d = S_ACQ;
`ifdef TMPDEC_AVG_EN
          if (frameCnt_q == 2'd3) begin
            publish    = 1'b1;
            pubVal     = accSum[CNT_W+1:2];
            frameCnt_d = '0;
            acc_d      = '0;
          end else begin
            frameCnt_d = frameCnt_q + 2'd1;
            acc_d      = accSum;
          end
`else
          publish = 1'b1;
          pubVal  = hCnt_q;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A new result may replace code only if the old one is gone or is being
    // taken in this very cycle; otherwise it is dropped and flagged.
    if (publish) begin
      if (!codeValid_q || code_ready) begin
        code_d      = pubVal;
        codeValid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State, counters, input synchronisers and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      prevClass_q   <= C_BLANK;
      preChrg_q     <= 1'b0;
      preChrgPrev_q <= 1'b0;
      phase_q       <= '0;
      hCnt_q        <= '0;
      nCnt_q        <= '0;
      code_q        <= '0;
      codeValid_q   <= 1'b0;
      ovf_q         <= 1'b0;
      frameErr_q    <= 1'b0;
`ifdef TMPDEC_AVG_EN
      frameCnt_q    <= '0;
      acc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      prevClass_q   <= curClass;
      preChrg_q     <= preChrg;
      preChrgPrev_q <= preChrg_q;
      phase_q       <= {PA, PB, PC, PD};
      hCnt_q        <= hCnt_d;
      nCnt_q        <= nCnt_d;
      code_q        <= code_d;
      codeValid_q   <= codeValid_d;
      ovf_q         <= ovf_d;
      frameErr_q    <= frameErr_d;
`ifdef TMPDEC_AVG_EN
      frameCnt_q    <= frameCnt_d;
      acc_q         <= acc_d;
`endif
    end
  end

  assign code       = code_q;
  assign code_valid = codeValid_q;
  assign ovf        = ovf_q;
  assign frame_err  = frameErr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/tmp_result_decoder.md
# tmp_result_decoder

Receive-side decoder for the temperature-sensor switch-control bus. The block watches the PA/PB/PC/PD phase pattern and the preChrg flag driven by the sensor sequencer, and counts high-charge against low-charge balancing events over a fixed window. It publishes the resulting density code to the digital back end over a valid/ready handshake. It sits beside the sequencer in the same clock domain and is its only consumer of phase information.

## Interface
- `CNT_W`, default 8: width of the event counters and of `code`.
- `N_SAMPLES`, default 128: charge events per frame; legal range 1 .. 2^CNT_W-1.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `preChrg` in 1: sequencer precharge flag.
- `PA`, `PB`, `PC`, `PD` in 1 each: sequencer phase switches.
- `code_ready` in 1: back end accepts `code`.
- `code` out CNT_W: number of high-charge events in the last published frame.
- `code_valid` out 1: `code` holds an unconsumed result.
- `ovf` out 1: sticky; a result was dropped because the previous one was not consumed.
- `frame_err` out 1: sticky; an illegal phase pattern was seen during ACQ.
- `busy` out 1: high while in ACQ or DONE.

## Operation
- Input stage: `preChrg` and PA..PD are registered once (`*_q`). Classification uses only registered values.
- Classes on PA..PD_q:
  - H = 1100 (PA,PB,PC,PD).
  - L = 1010.
  - OUT = x111.
  - BLANK = 0000.
  - Any other pattern is ILLEGAL.
- Event: the class differs from the previous cycle's class and the new class is H or L. Holding a class across multiple cycles counts once.
- States:
  - IDLE: counters zero. A falling edge of `preChrg_q` moves to ACQ.
  - ACQ:
    - H event: `h_cnt`+1 and `n_cnt`+1.
    - L event: `n_cnt`+1.
    - Move to DONE when `n_cnt` reaches N_SAMPLES, or on an OUT rising class with `n_cnt` ≥ 1 (short frame).
    - An OUT rising class with `n_cnt` = 0 is ignored.
    - ILLEGAL sets `frame_err`; counting continues.
  - DONE, one cycle:
    - Publish `h_cnt`.
    - Clear `h_cnt` and `n_cnt`, then return to ACQ. Frames run back-to-back.
- Publish rule:
  - If `code_valid` is 0, or `code_ready` is 1 in the same cycle: load `code` and set `code_valid`.
  - Otherwise drop the new result, keep the old `code`, and set `ovf`.
- Handshake:
  - Transfer occurs on any rising edge where `code_valid` and `code_ready` are both 1. `code_valid` then falls unless a new publish occurs in the same cycle.
  - `code` is stable while `code_valid` is 1.
  - `code_ready` may be high while `code_valid` is 0 without effect.
- `preChrg_q` = 1 in any state forces IDLE and clears the counters. `code`, `code_valid`, `ovf` and `frame_err` are untouched.
- Arithmetic: `h_cnt` ≤ `n_cnt` ≤ N_SAMPLES always holds, so no wrap is possible. Counters are unsigned CNT_W bits.
- Simultaneous events in one cycle resolve in this priority: reset > preChrg > publish > count.

## Timing
- Reset values: state IDLE, all counters 0, `code` 0, `code_valid` 0, `ovf` 0, `frame_err` 0, `busy` 0. All registered input copies reset to 0.
- The frame-completing event is present on PA..PD before edge k. `n_cnt` updates at edge k+1, DONE is entered at k+2, and `code_valid` is high after edge k+3.
- A `preChrg` fall before edge k gives ACQ after edge k+1.
- An ILLEGAL pattern before edge k sets `frame_err` after edge k+1.
- Reset mid-frame discards the partial frame. No publish occurs.

## Configuration
- `TMPDEC_AVG_EN` defined:
  - A 2-bit frame counter and a (CNT_W+2)-bit accumulator sum `h_cnt` over 4 frames.
  - Only every 4th DONE publishes, with value accumulator>>2 (truncated). The accumulator and frame counter then clear.
  - `preChrg` and `reset` clear both.
  - `ovf` applies only to these averaged publishes.
- `TMPDEC_AVG_EN` undefined: every DONE publishes `h_cnt` directly; no accumulator logic.

## Test plan
- N_SAMPLES=8, `code_ready`=1. Pulse `preChrg`, then 5 H and 3 L phases each separated by BLANK. Required: `code`=5 and `code_valid` high 3 cycles after the 8th event; `ovf`=0.
- H held for 4 cycles followed by BLANK. Required: counted as exactly 1 event.
- N_SAMPLES=8, 2 H, then OUT pattern 0111. Required: short frame with `code`=2.
- `code_ready`=0 over 2 complete frames (first 5, then 7). Required: `code` stays 5 and `ovf`=1. Raising `code_ready` then completes one transfer and `code_valid` falls.
- Pattern 1110 during ACQ, then `preChrg` asserted mid-frame. Required: `frame_err`=1, state IDLE, counters 0, `code` unchanged. Repeat with `reset` high: all outputs 0.
- `TMPDEC_AVG_EN` build: 4 frames with h=4,5,6,6. Required: a single publish with `code`=5 after the 4th frame.
